axi_ni_receive_flit_control: RTL

AXI_NI_RECEIVE_FLIT_CONTROL -- requirements
Module: axi_ni_receive_flit_control

---
 rtl/axi_ni_receive_flit_control_pkg.sv | 32 +++
 rtl/axi_ni_payload_buffer.sv | 39 +++
 rtl/axi_ni_receive_flit_control.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/axi_ni_receive_flit_control_pkg.sv
// Shared NoC flit-type encodings and field widths for the NI receive path.
// Optional feature macro used by the receive control: NI_RX_ERROR_CHECK_EN.
`default_nettype none

`ifndef FTYPEWD
`define FTYPEWD 2
`endif
`ifndef COUNTERFLITWD
`define COUNTERFLITWD 4
`endif

package axi_ni_receive_flit_control_pkg;

  typedef enum logic [`FTYPEWD-1:0] {
    FT_BODY     = 2'b00,
    FT_TAIL     = 2'b01,
    FT_HEAD     = 2'b10,
    FT_HEADTAIL = 2'b11
  } flit_type_t;

  // Bit 0 marks packet end, bit 1 marks packet start.
  function automatic logic is_tail(input logic [`FTYPEWD-1:0] t);
    return t[0];
  endfunction

  function automatic logic is_head(input logic [`FTYPEWD-1:0] t);
    return t[1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi_ni_payload_buffer.sv
// One-entry payload holding register; a new load wins over a same-cycle drain.
`default_nettype none

module axi_ni_payload_buffer
  import axi_ni_receive_flit_control_pkg::*;
#(
  parameter int DATA_WIDTH = 30
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  input  logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  last
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      last  <= load_last;
    end else if (ready) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load) data <= load_data;
  end

endmodule

`default_nettype wire

// File: rtl/axi_ni_receive_flit_control.sv
// NI receive flit control: captures header flits, hands the header off, then streams payload.
// Optional NI_RX_ERROR_CHECK_EN adds framing checks with a sticky protocol_error flag.
`default_nettype none

module axi_ni_receive_flit_control
  import axi_ni_receive_flit_control_pkg::*;
#(
  parameter int FLIT_WIDTH      = 32,
  parameter int REQ_HEADERFLITS = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [FLIT_WIDTH-1:0]           flit,
  input  logic                            flit_valid,
  output logic                            flit_ready,
  output logic                            sample_header,
  output logic [`COUNTERFLITWD-1:0]       flit_count,
  output logic                            header_valid,
  input  logic                            header_ack,
  output logic                            header_has_payload,
  output logic [FLIT_WIDTH-`FTYPEWD-1:0]  payload_data,
  output logic                            payload_valid,
  output logic                            payload_last,
  input  logic                            payload_ready,
  output logic                            protocol_error
);

  localparam int CW = `COUNTERFLITWD;
  localparam logic [CW-1:0] LAST_HDR = CW'(REQ_HEADERFLITS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    HANDOFF = 2'd2,
    PAYLOAD = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       counter, counter_nxt;
  logic                has_payload_nxt;
  logic                set_error;
  logic                load;
  logic                accept;
  logic [`FTYPEWD-1:0] ftype;
  logic                idle_drop, hdr_abort, pay_abort;

  assign ftype = flit[`FTYPEWD-1:0];

`ifdef NI_RX_ERROR_CHECK_EN
  assign idle_drop = !is_head(ftype);
  assign hdr_abort = (ftype == FT_HEAD) || (is_tail(ftype) && (counter != LAST_HDR));
  assign pay_abort = (ftype == FT_HEAD);
`else
  assign idle_drop = 1'b0;
  assign hdr_abort = 1'b0;
  assign pay_abort = 1'b0;
`endif

  // Ready depends only on registered state and the buffer, never on the incoming flit.
  assign flit_ready    = (state == HANDOFF) ? 1'b0 :
                         (state == PAYLOAD) ? (!payload_valid || payload_ready) : 1'b1;
  assign accept        = flit_valid && flit_ready;
  assign sample_header = accept && ((state == IDLE) || (state == HEADER));
  assign flit_count    = counter;
  assign header_valid  = (state == HANDOFF);

  always_comb begin
    state_nxt       = state;
    counter_nxt     = counter;
    has_payload_nxt = header_has_payload;
    set_error       = 1'b0;
    load            = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (idle_drop) begin
            set_error = 1'b1;
          end else begin
            state_nxt   = HEADER;
            counter_nxt = CW'(1);
          end
        end
      end
      HEADER: begin
        if (accept) begin
          if (hdr_abort) begin
            set_error   = 1'b1;
            state_nxt   = IDLE;
            counter_nxt = '0;
          end else if (counter == LAST_HDR) begin
            state_nxt       = HANDOFF;
            counter_nxt     = '0;
            has_payload_nxt = !is_tail(ftype);
          end else begin
            counter_nxt = counter + CW'(1);
          end
        end
      end
      HANDOFF: begin
        if (header_ack) state_nxt = header_has_payload ? PAYLOAD : IDLE;
      end
      PAYLOAD: begin
        if (accept) begin
          if (pay_abort) begin
            set_error = 1'b1;
            state_nxt = IDLE;
          end else begin
            load = 1'b1;
            if (is_tail(ftype)) state_nxt = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      counter            <= '0;
      header_has_payload <= 1'b0;
    end else begin
      state              <= state_nxt;
      counter            <= counter_nxt;
      header_has_payload <= has_payload_nxt;
    end
  end

`ifdef NI_RX_ERROR_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)            protocol_error <= 1'b0;
    else if (set_error) protocol_error <= 1'b1;
  end
`else
  logic unused_sig;
  assign protocol_error = 1'b0;
  assign unused_sig     = ^{set_error, ftype[1]};
`endif

  axi_ni_payload_buffer #(
    .DATA_WIDTH(FLIT_WIDTH - `FTYPEWD)
  ) u_payload_buffer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_data(flit[FLIT_WIDTH-1:`FTYPEWD]),
    .load_last(is_tail(ftype)),
    .ready    (payload_ready),
    .valid    (payload_valid),
    .data     (payload_data),
    .last     (payload_last)
  );

endmodule

`default_nettype wire
